// File: rtl/multi_ch_serializer.sv
// N-channel parallel-to-serial shifter: loads one word per channel, then shifts all channels
// out together one bit per beat under valid/ready, with per-frame bit order and inter-frame gap.
module multi_ch_serializer #(
    parameter int unsigned DATA_WD      = 10,
    parameter int unsigned CH_NUM       = 4,
    parameter int unsigned GAP_CYC      = 2,
    parameter int unsigned FRAME_CNT_WD = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [CH_NUM*DATA_WD-1:0]  in_data_i,
    input  logic                       lsb_first_i,
    output logic                       ser_valid_o,
    input  logic                       ser_ready_i,
    output logic [CH_NUM-1:0]          ser_data_o,
    output logic                       ser_sof_o,
    output logic                       ser_eof_o,
    output logic [FRAME_CNT_WD-1:0]    frame_cnt_o
);

    localparam int unsigned CntW = $clog2(DATA_WD);
    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CntW-1:0] BitLast = CntW'(DATA_WD - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e                                state_q, state_d;
    logic [CH_NUM-1:0][DATA_WD-1:0]        shreg_q, shreg_d;
    logic                                  lsb_q, lsb_d;
    logic [CntW-1:0]                       bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]                       gap_cnt_q, gap_cnt_d;
    logic [FRAME_CNT_WD-1:0]               frame_cnt_q, frame_cnt_d;
    logic                                  in_ready_q, in_ready_d;
    logic                                  ser_valid_q, ser_valid_d;
    logic [CH_NUM-1:0]                     ser_data_q, ser_data_d;
    logic                                  ser_sof_q, ser_sof_d;
    logic                                  ser_eof_q, ser_eof_d;
    logic                                  beat_acc;

    assign beat_acc = (state_q == StShift) && ser_valid_q && ser_ready_i;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        lsb_d       = lsb_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (clear_i) begin
            // Abort drops the frame in flight; the completed-frame count is kept.
            state_d   = StIdle;
            shreg_d   = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i && in_ready_q) begin
                        shreg_d   = in_data_i;
                        lsb_d     = lsb_first_i;
                        bit_cnt_d = '0;
                        state_d   = StShift;
                    end
                end
                StShift: begin
                    if (beat_acc) begin
                        if (bit_cnt_q == BitLast) begin
                            frame_cnt_d = frame_cnt_q + FRAME_CNT_WD'(1);
                            shreg_d     = '0;
                            bit_cnt_d   = '0;
                            gap_cnt_d   = '0;
                            state_d     = (GAP_CYC > 0) ? StGap : StIdle;
                        end else begin
                            for (int unsigned c = 0; c < CH_NUM; c++) begin
                                shreg_d[c] = lsb_q ? (shreg_q[c] >> 1) : (shreg_q[c] << 1);
                            end
                            bit_cnt_d = bit_cnt_q + CntW'(1);
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        gap_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GapW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered copies of what the next state presents.
    always_comb begin
        in_ready_d  = (state_d == StIdle) && !clear_i;
        ser_valid_d = (state_d == StShift);
        ser_sof_d   = ser_valid_d && (bit_cnt_d == '0);
        ser_eof_d   = ser_valid_d && (bit_cnt_d == BitLast);
        ser_data_d  = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            ser_data_d[c] = ser_valid_d && (lsb_d ? shreg_d[c][0] : shreg_d[c][DATA_WD-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            lsb_q       <= 1'b0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_data_q  <= '0;
            ser_sof_q   <= 1'b0;
            ser_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            lsb_q       <= lsb_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            in_ready_q  <= in_ready_d;
            ser_valid_q <= ser_valid_d;
            ser_data_q  <= ser_data_d;
            ser_sof_q   <= ser_sof_d;
            ser_eof_q   <= ser_eof_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign ser_valid_o = ser_valid_q;
    assign ser_data_o  = ser_data_q;
    assign ser_sof_o   = ser_sof_q;
    assign ser_eof_o   = ser_eof_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_multi_ch_serializer.sv
// Bench for multi_ch_serializer: frame-level reference model compared every cycle, plus
// directed scenarios with hand-computed bit sequences and counter values.
module tb_multi_ch_serializer;

    localparam int DW  = 10;
    localparam int CH  = 4;
    localparam int GAP = 2;
    localparam int FCW = 3;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic              clear_i     = 1'b0;
    logic              in_valid_i  = 1'b0;
    logic              lsb_first_i = 1'b0;
    logic              ser_ready_i = 1'b0;
    logic [CH*DW-1:0]  in_data_i   = '0;
    logic              in_ready_o;
    logic              ser_valid_o;
    logic              ser_sof_o;
    logic              ser_eof_o;
    logic [CH-1:0]     ser_data_o;
    logic [FCW-1:0]    frame_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_ch_serializer #(
        .DATA_WD      (DW),
        .CH_NUM       (CH),
        .GAP_CYC      (GAP),
        .FRAME_CNT_WD (FCW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .lsb_first_i (lsb_first_i),
        .ser_valid_o (ser_valid_o),
        .ser_ready_i (ser_ready_i),
        .ser_data_o  (ser_data_o),
        .ser_sof_o   (ser_sof_o),
        .ser_eof_o   (ser_eof_o),
        .frame_cnt_o (frame_cnt_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a word per channel plus a beat index; the gap is a countdown.
    logic [DW-1:0] m_word [CH];
    logic          m_lsb  = 1'b0;
    logic          m_rdy  = 1'b0;
    int            m_beat = -1;
    int            m_gap  = 0;
    int            m_fcnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy  = 1'b0;
            m_beat = -1;
            m_gap  = 0;
            m_fcnt = 0;
        end else if (clear_i) begin
            m_rdy  = 1'b0;
            m_beat = -1;
            m_gap  = 0;
        end else begin
            if (m_beat < 0 && m_gap == 0) begin
                if (m_rdy && in_valid_i) begin
                    for (int c = 0; c < CH; c++) m_word[c] = in_data_i[c*DW +: DW];
                    m_lsb  = lsb_first_i;
                    m_beat = 0;
                end
            end else if (m_beat >= 0) begin
                if (ser_ready_i) begin
                    if (m_beat == DW - 1) begin
                        m_beat = -1;
                        m_gap  = GAP;
                        m_fcnt = (m_fcnt + 1) % (1 << FCW);
                    end else begin
                        m_beat++;
                    end
                end
            end else begin
                m_gap--;
            end
            m_rdy = (m_beat < 0 && m_gap == 0);
        end
    end

    always @(negedge clk) begin : cmp
        logic [CH-1:0] ed;
        if (rst_n) begin
            ed = '0;
            if (m_beat >= 0)
                for (int c = 0; c < CH; c++)
                    ed[c] = m_lsb ? m_word[c][m_beat] : m_word[c][DW-1-m_beat];
            check("cycle {rdy,vld,sof,eof,data,fcnt}",
                  {in_ready_o, ser_valid_o, ser_sof_o, ser_eof_o, ser_data_o, frame_cnt_o},
                  {m_rdy, m_beat >= 0, m_beat == 0, m_beat == DW - 1, ed, FCW'(m_fcnt)});
        end
    end

    // Beat recorder: outputs captured mid-cycle, committed when the handshake edge arrives.
    logic          p_valid = 1'b0, p_sof = 1'b0, p_eof = 1'b0, p_bit = 1'b0;
    logic [DW-1:0] seq0   = '0;
    int            nbeats = 0, vcyc = 0, sof_at = 0, eof_at = 0;

    always @(negedge clk) begin
        p_valid = ser_valid_o;
        p_sof   = ser_sof_o;
        p_eof   = ser_eof_o;
        p_bit   = ser_data_o[0];
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (p_valid) vcyc++;
            if (p_valid && ser_ready_i) begin
                nbeats++;
                seq0 = {seq0[DW-2:0], p_bit};
                if (p_sof) sof_at = nbeats;
                if (p_eof) eof_at = nbeats;
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 100 && !in_ready_o; i++) @(negedge clk);
        check("in_ready timeout", in_ready_o, 1'b1);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 200 && nbeats < n; i++) @(negedge clk);
        check("beat count timeout", nbeats, n);
    endtask

    task automatic send(input logic [CH*DW-1:0] d, input logic lsb);
        wait_ready();
        nbeats = 0; vcyc = 0; sof_at = 0; eof_at = 0; seq0 = '0;
        in_data_i   = d;
        lsb_first_i = lsb;
        in_valid_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_i  = 1'b0;
        lsb_first_i = ~lsb;  // order must stay frozen for the frame
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gapn;
        // 1: reset values and ready rise after release
        repeat (2) @(negedge clk);
        check("reset outputs", {in_ready_o, ser_valid_o, ser_sof_o, ser_eof_o, ser_data_o,
                                frame_cnt_o}, 11'h0);
        #1 rst_n = 1'b1;
        #1 check("ready before first edge", in_ready_o, 1'b0);
        @(negedge clk);
        check("ready after first edge", in_ready_o, 1'b1);

        // 2: LSB-first, no backpressure
        ser_ready_i = 1'b1;
        send({10'h3FF, 10'h001, 10'h155, 10'h295}, 1'b1);
        wait_beats(10);
        check("lsb seq ch0", seq0, 10'b1010100101);
        check("sof beat", sof_at, 1);
        check("eof beat", eof_at, 10);
        check("frame valid cycles", vcyc, 10);
        gapn = 0;
        for (int i = 0; i < 20 && !in_ready_o; i++) begin
            if (!ser_valid_o) gapn++;
            @(negedge clk);
        end
        check("gap cycles", gapn, 2);
        check("frames after t2", frame_cnt_o, 3'd1);

        // 3: MSB-first with a 3-cycle stall on beat 4
        send({10'h3FF, 10'h001, 10'h155, 10'h295}, 1'b0);
        repeat (3) @(negedge clk);
        ser_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        ser_ready_i = 1'b1;
        wait_beats(10);
        check("msb seq ch0", seq0, 10'b1010010101);
        check("stalled frame span", vcyc, 13);

        // 4: abort on beat 6, then a clean frame
        send({10'h2AA, 10'h0C3, 10'h3F0, 10'h123}, 1'b1);
        repeat (5) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("valid after clear", ser_valid_o, 1'b0);
        check("fcnt after clear", frame_cnt_o, 3'd2);
        check("ready on clear edge", in_ready_o, 1'b0);
        @(negedge clk);
        check("ready after clear", in_ready_o, 1'b1);
        send({10'h111, 10'h222, 10'h333, 10'h0F3}, 1'b1);
        wait_beats(10);
        check("post-clear seq ch0", seq0, 10'b1100111100);

        // 5: nine back-to-back frames with in_valid held high
        do_reset();
        in_valid_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < CH; c++) in_data_i[c*DW +: DW] = DW'(k * 97 + c * 211 + 3);
            lsb_first_i = k[0];
            wait_ready();
            @(posedge clk);
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        wait_ready();
        check("fcnt after wrap", frame_cnt_o, 3'd1);

        // 6: async reset in the middle of beat 5
        send({10'h000, 10'h3FF, 10'h2D2, 10'h1C6}, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", ser_valid_o, 1'b0);
        check("async rst eof", ser_eof_o, 1'b0);
        check("async rst fcnt", frame_cnt_o, 3'd0);
        check("async rst data", ser_data_o, 4'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        send({10'h000, 10'h3FF, 10'h2D2, 10'h1C6}, 1'b1);
        wait_beats(10);
        check("restart seq ch0", seq0, 10'b0110001110);
        wait_ready();
        check("fcnt after restart", frame_cnt_o, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
